// File: rtl/cmp_arbiter_pkg.sv
// Shared types for the compare arbiter: compare-op encodings, requester ids
// and counter limits.
package rv32i_types;

  // RV32I conditional-branch funct3 field.
  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } branch_funct3_t;

  // Comparator op: the branch encodings plus slt/sltu in the unused slots.
  typedef enum logic [2:0] {
    CMP_BEQ  = 3'b000,
    CMP_BNE  = 3'b001,
    CMP_SLT  = 3'b010,
    CMP_SLTU = 3'b011,
    CMP_BLT  = 3'b100,
    CMP_BGE  = 3'b101,
    CMP_BLTU = 3'b110,
    CMP_BGEU = 3'b111
  } cmpop_t;

  localparam logic        REQ_BRANCH   = 1'b0;   // requester 0: branch EX path
  localparam logic        REQ_ALU      = 1'b1;   // requester 1: slt/sltu ALU path
  localparam logic [15:0] CONFLICT_MAX = 16'hFFFF;

endpackage

// File: rtl/cmp_arbiter_if.sv
// Request/response bundle between the two requesters, the consumer and the
// shared comparator arbiter.
interface cmp_arbiter_if import rv32i_types::*; #(parameter int TAG_W = 4);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [31:0]      req_a0, req_b0, req_a1, req_b1;
  cmpop_t           req_op0, req_op1;
  logic [TAG_W-1:0] req_tag0, req_tag1;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_result;
  logic             flush;
  logic [15:0]      conflict_cnt;

  // Requesters and consumer side.
  modport master (
    output req_valid, req_a0, req_b0, req_a1, req_b1, req_op0, req_op1,
           req_tag0, req_tag1, rsp_ready, flush,
    input  req_ready, rsp_valid, rsp_id, rsp_tag, rsp_result, conflict_cnt
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_a0, req_b0, req_a1, req_b1, req_op0, req_op1,
           req_tag0, req_tag1, rsp_ready, flush,
    output req_ready, rsp_valid, rsp_id, rsp_tag, rsp_result, conflict_cnt
  );
endinterface

// File: rtl/cmp_arbiter_cmp.sv
// Shared 32-bit comparator: equality, signed and unsigned ordering.
module cmp import rv32i_types::*; (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  cmpop_t      op_i,
  output logic        result_o
);

  // Evaluate the selected comparison.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    result_o = 1'b0;
    case (op_i)
      CMP_BEQ:            result_o = (a_i == b_i);
      CMP_BNE:            result_o = (a_i != b_i);
      CMP_SLT,  CMP_BLT:  result_o = ($signed(a_i) <  $signed(b_i));
      CMP_BGE:            result_o = ($signed(a_i) >= $signed(b_i));
      CMP_SLTU, CMP_BLTU: result_o = (a_i <  b_i);
      CMP_BGEU:           result_o = (a_i >= b_i);
      default:            result_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cmp_arbiter.sv
// Two-requester round-robin arbiter in front of one shared comparator, with a
// single registered result slot and a saturating conflict counter.
module cmp_arbiter import rv32i_types::*; #(
  parameter int TAG_W = 4
) (
  input logic          clk,
  input logic          rst_n,
  cmp_arbiter_if.slave bus
);

  logic             last_grant_q, last_grant_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic             rsp_result_q, rsp_result_d;
  logic [15:0]      conflict_q, conflict_d;

  logic             both_valid, any_valid, accept_ok, accept, grant_id;
  logic [1:0]       req_ready;
  logic [31:0]      a_mux, b_mux;
  cmpop_t           op_mux;
  logic [TAG_W-1:0] tag_mux;
  logic             cmp_result;

  // Grant selection: a sole requester wins; on conflict the one not granted last.
  // Ready depends on valids only, never on request data; held low in reset.
  always_comb begin
    both_valid = &bus.req_valid;
    any_valid  = |bus.req_valid;
    accept_ok  = rst_n && !bus.flush && (!rsp_valid_q || bus.rsp_ready);
    grant_id   = both_valid ? ~last_grant_q : bus.req_valid[REQ_ALU];
    accept     = accept_ok && any_valid;
    req_ready  = '0;
    if (accept) req_ready[grant_id] = 1'b1;
  end

  assign bus.req_ready = req_ready;

  // Route the granted requester's operands, op and tag into the comparator.
  always_comb begin
    a_mux   = bus.req_a0;
    b_mux   = bus.req_b0;
    op_mux  = bus.req_op0;
    tag_mux = bus.req_tag0;
    if (grant_id == REQ_ALU) begin
      a_mux   = bus.req_a1;
      b_mux   = bus.req_b1;
      op_mux  = bus.req_op1;
      tag_mux = bus.req_tag1;
    end
  end

  cmp u_cmp (
    .a_i      (a_mux),
    .b_i      (b_mux),
    .op_i     (op_mux),
    .result_o (cmp_result)
  );

  // Next state: load on accept (drain+load on one edge), else drop on
  // ready/flush, else hold; counter saturates on conflicts.
  always_comb begin
    last_grant_d = last_grant_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_tag_d    = rsp_tag_q;
    rsp_result_d = rsp_result_q;
    conflict_d   = conflict_q;
    if (accept) begin
      last_grant_d = grant_id;
      rsp_valid_d  = 1'b1;
      rsp_id_d     = grant_id;
      rsp_tag_d    = tag_mux;
      rsp_result_d = cmp_result;
    end else if (bus.rsp_ready || bus.flush) begin
      rsp_valid_d  = 1'b0;
    end
    if (both_valid && (conflict_q != CONFLICT_MAX)) conflict_d = conflict_q + 16'd1;
  end

  // State registers; last_grant resets to requester 1 so requester 0 wins first.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= REQ_ALU;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= REQ_BRANCH;
      rsp_tag_q    <= '0;
      rsp_result_q <= 1'b0;
      conflict_q   <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_tag_q    <= rsp_tag_d;
      rsp_result_q <= rsp_result_d;
      conflict_q   <= conflict_d;
    end
  end

  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_id       = rsp_id_q;
  assign bus.rsp_tag      = rsp_tag_q;
  assign bus.rsp_result   = rsp_result_q;
  assign bus.conflict_cnt = conflict_q;

endmodule
